// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
//   Single-byte I2C master. A write sends S, {dev_addr,0}, reg_addr, wdata, P
//   and checks the slave ACK after every byte. A read sends S, {dev_addr,1},
//   clocks in one byte from the slave, answers with NACK and sends P.
//   SCL is derived from clk; each bit-time is four quarters of CLK_DIV clk
//   cycles each. SDA is open-drain (driven low or released).
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-low
//   start     one-cycle request, only honoured in IDLE
//   rw        0 = write, 1 = read (captured with start)
//   dev_addr  7-bit slave address (captured with start)
//   reg_addr  register byte for writes (captured with start)
//   wdata     data byte for writes (captured with start)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse at the end of every transaction
//   ack_err   1 = slave NACKed; holds until the next accepted start
//   rdata     byte returned by the last successful read
//   SDA       open-drain serial data
//   SCL       push-pull serial clock (no clock stretching)
module i2c_master_ctrl #(
    parameter int CLK_DIV = 625
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    inout  wire        SDA,
    output logic       SCL
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDAT,
        S_WDAT_ACK,
        S_RDAT,
        S_RNACK,
        S_STOP,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic [7:0]       rdata_q, rdata_d;

    logic             rw_q, rw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdat_q, wdat_d;
    logic [7:0]       rx_q, rx_d;

    logic             tick;
    logic             sample;
    logic             bit_end;
    logic             sda_in;
    logic [7:0]       tx_byte;
    logic             tx_bit;
    logic             scl;
    logic             sda_oe;

    assign sda_in  = SDA;
    assign tick    = (div_q == DIV_LAST);
    // SDA is sampled at the end of q2, after SCL has been high for two quarters.
    assign sample  = tick && (qtr_q == 2'd2);
    assign bit_end = tick && (qtr_q == 2'd3);

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            S_ADDR:  tx_byte = {dev_q, rw_q};
            S_REG:   tx_byte = reg_q;
            S_WDAT:  tx_byte = wdat_q;
            default: tx_byte = 8'h00;
        endcase
    end

    assign tx_bit = tx_byte[bit_q];

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;

        // Quarter timing only runs while a transaction is in flight, so every
        // transaction starts on a fresh q0.
        if (state_q == S_IDLE) begin
            div_d = '0;
            qtr_d = 2'd0;
        end else if (tick) begin
            div_d = '0;
            qtr_d = qtr_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d      = rw;
                    dev_d     = dev_addr;
                    reg_d     = reg_addr;
                    wdat_d    = wdata;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = 3'd7;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_REG, S_WDAT: begin
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        case (state_q)
                            S_ADDR:  state_d = S_ADDR_ACK;
                            S_REG:   state_d = S_REG_ACK;
                            default: state_d = S_WDAT_ACK;
                        endcase
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_ADDR_ACK, S_REG_ACK, S_WDAT_ACK: begin
                if (sample && sda_in) begin
                    ack_err_d = 1'b1;
                end
                // ack_err_q already holds the q2 sample when the bit ends.
                if (bit_end) begin
                    bit_d = 3'd7;
                    if (ack_err_q) begin
                        state_d = S_STOP;
                    end else begin
                        case (state_q)
                            S_ADDR_ACK: state_d = rw_q ? S_RDAT : S_REG;
                            S_REG_ACK:  state_d = S_WDAT;
                            default:    state_d = S_STOP;
                        endcase
                    end
                end
            end
            S_RDAT: begin
                if (sample) begin
                    rx_d = {rx_q[6:0], sda_in};
                end
                if (bit_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_RNACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_RNACK: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // done, busy and rdata are registered on entry to FIN so they
                // are all presented during the FIN cycle itself.
                if (bit_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rw_q && !ack_err_q) begin
                        rdata_d = rx_q;
                    end
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus levels decoded from state and quarter. Data bits hold SCL high for
    // q1..q2 and change SDA only in q0; START and STOP are the two places
    // where SDA moves under a high SCL.
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            S_START: begin
                scl    = (qtr_q != 2'd3);
                sda_oe = qtr_q[1];
            end
            S_ADDR, S_REG, S_WDAT: begin
                scl    = qtr_q[0] ^ qtr_q[1];
                sda_oe = ~tx_bit;
            end
            S_ADDR_ACK, S_REG_ACK, S_WDAT_ACK, S_RDAT, S_RNACK: begin
                scl    = qtr_q[0] ^ qtr_q[1];
                sda_oe = 1'b0;
            end
            S_STOP: begin
                scl    = (qtr_q != 2'd0);
                sda_oe = ~qtr_q[1];
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Captured request and receive shift register carry no reset; they are
    // always written before being used.
    always_ff @(posedge clk) begin
        rw_q   <= rw_d;
        dev_q  <= dev_d;
        reg_q  <= reg_d;
        wdat_q <= wdat_d;
        rx_q   <= rx_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign SCL     = scl;
    assign SDA     = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave on an open-drain bus with
// pull-up, randomized transactions, expected results queued at issue time and
// checked by an independent monitor on every done pulse.
module tb_i2c_master_ctrl;

    localparam int         CLK_DIV    = 2;
    localparam int         BT         = 4 * CLK_DIV;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic       rw       = 1'b0;
    logic [6:0] dev_addr = 7'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata    = 8'h00;
    wire        busy;
    wire        done;
    wire        ack_err;
    wire  [7:0] rdata;
    wire        scl;
    wire        sda;

    logic       slv_oe = 1'b0;

    pullup (sda);
    assign sda = slv_oe ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rdata    (rdata),
        .SDA      (sda),
        .SCL      (scl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // ---------------- expected-result queue ----------------
    typedef struct packed {
        logic        ack_err;
        logic [7:0]  rdata;
        logic [31:0] lat;
        logic [31:0] nfr;
        logic [26:0] frames;
        logic [31:0] t0;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_rdata = 8'h00;
    int         done_cnt    = 0;
    int         txn_cnt     = 0;

    // ---------------- behavioural slave + bus observer ----------------
    logic [8:0] frames[$];
    logic [7:0] slv_rdata = 8'h00;
    int         s_cnt = 0;
    int         p_cnt = 0;
    int         n = 0;
    int         pos;
    int         bn;
    logic [7:0] sh = 8'h00;
    logic       addressed = 1'b0;
    logic       rd = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    // Frame k covers SCL pulses 9k..9k+8: eight data bits then the ack slot.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                slv_oe    = 1'b0;
                n         = 0;
                addressed = 1'b0;
            end else if (scl && scl_p && sda_p && !sda) begin
                s_cnt++;
                n         = 0;
                addressed = 1'b0;
                slv_oe    = 1'b0;
            end else if (scl && scl_p && !sda_p && sda) begin
                p_cnt++;
                slv_oe = 1'b0;
            end else if (scl && !scl_p) begin
                pos = n % 9;
                bn  = n / 9;
                if (pos < 8) sh = {sh[6:0], sda};
                if (pos == 7 && bn == 0) begin
                    addressed = (sh[7:1] == SLAVE_ADDR);
                    rd        = sh[0];
                end
                if (pos == 8) frames.push_back({sh, sda});
                n++;
            end else if (!scl && scl_p) begin
                pos    = n % 9;
                bn     = n / 9;
                slv_oe = addressed &&
                         ((pos == 8 && !(rd && bn >= 1)) ||
                          (rd && bn == 1 && pos < 8 && !slv_rdata[7 - pos]));
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    // ---------------- monitor ----------------
    exp_t        e;
    logic [26:0] act_fr;

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_err", ack_err, e.ack_err);
                    check("rdata", rdata, e.rdata);
                    check("latency", cyc - e.t0 + 1, e.lat);
                    check("busy_at_done", busy, 0);
                    check("frame_count", frames.size(), e.nfr);
                    act_fr = '0;
                    for (int i = 0; i < frames.size() && i < 3; i++) act_fr[9*i +: 9] = frames[i];
                    check("frames", act_fr, e.frames);
                    check("start_cond", s_cnt, 1);
                    check("stop_cond", p_cnt, 1);
                end
                frames.delete();
                s_cnt = 0;
                p_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                          input logic [7:0] wd, input logic [7:0] sr, input int extra);
        exp_t x;
        int   c0;
        int   w;
        logic ok;
        @(negedge clk);
        slv_rdata = sr;
        ok        = (d == SLAVE_ADDR);
        x         = '0;
        x.frames[8:0] = {d, r, !ok};
        if (!ok) begin
            x.nfr     = 1;
            x.lat     = 11 * BT + 2;
            x.ack_err = 1'b1;
        end else if (r) begin
            x.nfr          = 2;
            x.lat          = 20 * BT + 2;
            x.frames[17:9] = {sr, 1'b1};
            model_rdata    = sr;
        end else begin
            x.nfr           = 3;
            x.lat           = 29 * BT + 2;
            x.frames[17:9]  = {ra, 1'b0};
            x.frames[26:18] = {wd, 1'b0};
        end
        x.rdata = model_rdata;
        x.t0    = cyc;
        exp_q.push_back(x);
        txn_cnt++;
        c0       = done_cnt;
        start    = 1'b1;
        rw       = r;
        dev_addr = d;
        reg_addr = ra;
        wdata    = wd;
        @(negedge clk);
        start    = 1'b0;
        rw       = 1'($urandom);
        dev_addr = 7'($urandom);
        reg_addr = 8'($urandom);
        wdata    = 8'($urandom);
        for (int k = 0; k < extra; k++) begin
            repeat ($urandom_range(5, 40)) @(negedge clk);
            if (busy) begin
                start    = 1'b1;
                rw       = 1'($urandom);
                dev_addr = 7'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
        end
        w = 0;
        while (done_cnt == c0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (done_cnt == c0) begin
            check("done_timeout", done_cnt, c0 + 1);
            exp_q.delete();
        end
    endtask

    int         dc;
    logic       r;
    logic [6:0] d;

    initial begin
        // Reset held for three clocks.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0);
        do_txn(1'b1, 7'h50, 8'h00, 8'h00, 8'h3C, 0);
        do_txn(1'b1, 7'h22, 8'h00, 8'h00, 8'h77, 0);
        do_txn(1'b0, 7'h50, 8'h9E, 8'h41, 8'h00, 3);

        for (int i = 0; i < 14; i++) begin
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 9) < 7) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_txn(r, d, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
        end

        // Reset in the middle of the data byte of a write.
        @(negedge clk);
        dc       = done_cnt;
        start    = 1'b1;
        rw       = 1'b0;
        dev_addr = SLAVE_ADDR;
        reg_addr = 8'h33;
        wdata    = 8'hCC;
        @(negedge clk);
        start = 1'b0;
        repeat (22 * BT - 1) @(negedge clk);
        check("busy_before_reset", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b1;
        frames.delete();
        s_cnt       = 0;
        p_cnt       = 0;
        model_rdata = 8'h00;
        repeat (40) @(negedge clk);
        check("no_done_after_reset", done_cnt, dc);
        check("rdata_after_reset", rdata, 0);
        do_txn(1'b0, 7'h50, 8'h5A, 8'hC3, 8'h00, 0);
        do_txn(1'b1, 7'h50, 8'h00, 8'h00, 8'h81, 0);

        repeat (20) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        check("done_pulses", done_cnt, txn_cnt);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
